raw_image_read_arbiter: RTL

Shares the single read port of the raw-image byte memory (390×390 8-bit pixels, 152100 entries) between two requesters: the display scanner (requester 0) and the image-processing core (requester 1). Fair round-robin arbitration, one grant per cycle, range checking of addresses, and in-order return of read data tagged to the owning requester. Sits directly in front of the raw-image memory; requesters never drive the memory port directly.

---
 rtl/raw_img_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 32 +++
 rtl/raw_image_read_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/raw_img_pkg.sv
// Raw-image memory constants and the read-return tag type,
// shared by the memory, arbiter and processing blocks.
package raw_img_pkg;

    localparam int IMG_W     = 390;
    localparam int IMG_H     = 390;
    localparam int MEM_DEPTH = IMG_W * IMG_H;
    localparam int ADDR_W    = 18;
    localparam int PIX_W     = 8;

    typedef struct packed {
        logic valid;
        logic owner;
        logic err;
    } tag_t;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return a < ADDR_W'(MEM_DEPTH);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter, one-hot combinational grant.
// On a tie the requester not served last wins.
module rr_arbiter2 (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_served;

    always_comb begin
        gnt = 2'b00;
        if (!RST) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_served ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_served <= 1'b1;
        end else if (|gnt) begin
            last_served <= gnt[1];
        end
    end

endmodule

// File: rtl/raw_image_read_arbiter.sv
// Shares the raw-image memory read port between the display scanner (0)
// and the processing core (1); returns data in grant order, tagged by owner.
module raw_image_read_arbiter
    import raw_img_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [PIX_W-1:0]  rdata0,
    output logic [PIX_W-1:0]  rdata1,
    output logic              err0,
    output logic              err1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic              busy
);

    logic [1:0]           gnt;
    logic [ADDR_W-1:0]    gnt_addr;
    logic                 hit;
    logic                 inflight;
    tag_t                 tag_in;
    tag_t                 tag_out;
    tag_t [MEM_LATENCY:0] tags;

    rr_arbiter2 u_arb (
        .CLK (CLK),
        .RST (RST),
        .req ({req1, req0}),
        .gnt (gnt)
    );

    assign gnt0     = gnt[0];
    assign gnt1     = gnt[1];
    assign gnt_addr = gnt[1] ? addr1 : addr0;
    assign hit      = addr_in_range(gnt_addr);

    assign tag_in.valid = |gnt;
    assign tag_in.owner = gnt[1];
    assign tag_in.err   = |gnt & ~hit;

    assign tag_out = tags[MEM_LATENCY];

    // Out-of-range grants skip the memory but still occupy a return slot.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mem_addr <= '0;
            mem_re   <= 1'b0;
        end else begin
            mem_re <= |gnt & hit;
            if (|gnt & hit) begin
                mem_addr <= gnt_addr;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tags <= '0;
        end else begin
            tags <= {tags[MEM_LATENCY-1:0], tag_in};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= tag_out.valid & ~tag_out.owner;
            rvalid1 <= tag_out.valid & tag_out.owner;
            err0    <= tag_out.valid & ~tag_out.owner & tag_out.err;
            err1    <= tag_out.valid & tag_out.owner & tag_out.err;
            if (tag_out.valid & ~tag_out.owner) begin
                rdata0 <= tag_out.err ? '0 : mem_rdata;
            end
            if (tag_out.valid & tag_out.owner) begin
                rdata1 <= tag_out.err ? '0 : mem_rdata;
            end
        end
    end

    always_comb begin
        inflight = 1'b0;
        for (int i = 0; i <= MEM_LATENCY; i++) begin
            inflight = inflight | tags[i].valid;
        end
    end

    assign busy = inflight | mem_re;

endmodule
